// File: rtl/matrix_ops.sv
// matrix_ops
//   Serial-interface 2x2 matrix unit. Holds two 2x2 matrices A and B with
//   2-bit elements, loaded over a strobed 2-bit X/Y bus. READ, ADD and MUL
//   results are streamed out bit-serially on Z as a 9-bit frame: one start
//   bit, then element0..element3, each MSB first.
//   Element index: 0=r0c0, 1=r0c1, 2=r1c0, 3=r1c1.
//
// Ports
//   clk    in   rising-edge system clock
//   rst    in   asynchronous active-low reset
//   enter  in   strobe qualifying X/Y on the current rising edge
//   X      in   [1:0] opcode (command beat) or element address (write beat)
//   Y      in   [1:0] argument (command beat, Y[0]=matrix select) or data
//   Z      out  registered serial output, idles 0

module matrix_ops (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter,
    input  logic [1:0] X,
    input  logic [1:0] Y,
    output logic       Z
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] mat_a [4];
    logic [1:0] mat_b [4];
    logic       msel;
    logic [1:0] beat_cnt;
    logic [3:0] bit_cnt;
    logic [7:0] frame;

    logic [7:0] read_a_frame;
    logic [7:0] read_b_frame;
    logic [7:0] add_frame;
    logic [7:0] mul_frame;
    logic [7:0] cmd_frame;
    logic       cmd_ok;

    // All arithmetic is in 2-bit context, so sums and products wrap mod 4.
    always_comb begin
        read_a_frame = {mat_a[0], mat_a[1], mat_a[2], mat_a[3]};
        read_b_frame = {mat_b[0], mat_b[1], mat_b[2], mat_b[3]};
        add_frame    = {mat_a[0] + mat_b[0], mat_a[1] + mat_b[1],
                        mat_a[2] + mat_b[2], mat_a[3] + mat_b[3]};
        mul_frame    = {mat_a[0] * mat_b[0] + mat_a[1] * mat_b[2],
                        mat_a[0] * mat_b[1] + mat_a[1] * mat_b[3],
                        mat_a[2] * mat_b[0] + mat_a[3] * mat_b[2],
                        mat_a[2] * mat_b[1] + mat_a[3] * mat_b[3]};
    end

    always_comb begin
        cmd_frame = '0;
        case (X)
            2'd1:    cmd_frame = Y[0] ? read_b_frame : read_a_frame;
            2'd2:    cmd_frame = add_frame;
            2'd3:    cmd_frame = mul_frame;
            default: cmd_frame = '0;
        endcase
    end

    // A command is accepted in IDLE and also on the frame's closing edge,
    // which lets streams run back to back.
    assign cmd_ok = enter && ((state == IDLE) ||
                              (state == STREAM && bit_cnt == 4'd9));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mat_a    <= '{default: '0};
            mat_b    <= '{default: '0};
            msel     <= 1'b0;
            beat_cnt <= '0;
            bit_cnt  <= '0;
            frame    <= '0;
            Z        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Z <= 1'b0;
                end
                WR: begin
                    if (enter) begin
                        if (msel)
                            mat_b[X] <= Y;
                        else
                            mat_a[X] <= Y;
                        beat_cnt <= beat_cnt + 2'd1;
                        if (beat_cnt == 2'd3)
                            state <= IDLE;
                    end
                end
                STREAM: begin
                    if (bit_cnt == 4'd0) begin
                        Z <= 1'b1;
                    end else if (bit_cnt == 4'd9) begin
                        Z     <= 1'b0;
                        state <= IDLE;
                    end else begin
                        Z     <= frame[7];
                        frame <= {frame[6:0], 1'b0};
                    end
                    bit_cnt <= bit_cnt + 4'd1;
                end
                default: begin
                    Z     <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // Placed last so a command on the closing edge overrides the
            // frame-end return to IDLE.
            if (cmd_ok) begin
                msel     <= Y[0];
                beat_cnt <= '0;
                bit_cnt  <= '0;
                if (X == 2'd0) begin
                    state <= WR;
                end else begin
                    state <= STREAM;
                    frame <= cmd_frame;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_ops.sv
module tb_matrix_ops;

    logic       clk = 1'b0;
    logic       rst;
    logic       enter;
    logic [1:0] X;
    logic [1:0] Y;
    logic       Z;

    always #5 clk = ~clk;

    matrix_ops dut (
        .clk  (clk),
        .rst  (rst),
        .enter(enter),
        .X    (X),
        .Y    (Y),
        .Z    (Z)
    );

    int checks = 0;
    int errors = 0;
    int ma[4];
    int mb[4];

    typedef struct {
        string      name;
        int         op;
        logic       sel;
        logic [9:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic [1:0] x, input logic [1:0] y);
        enter = en;
        X     = x;
        Y     = y;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    endtask

    // Command beat; Y[1] is randomised because it must be ignored.
    task automatic issue(input int op, input logic sel);
        step(1'b1, 2'(op), {1'($urandom_range(0, 1)), sel});
    endtask

    // Samples Z after E1..E10. With chain set, a new command is presented on E10.
    task automatic collect(input logic chain, input int cop, input logic csel,
                           output logic [9:0] got);
        got = '0;
        for (int k = 0; k < 10; k++) begin
            if (k == 9 && chain)
                step(1'b1, 2'(cop), {1'b0, csel});
            else
                idle_step();
            got = {got[8:0], Z};
        end
    endtask

    // Reference: whole result frame from matrix arithmetic on the model.
    function automatic logic [9:0] expected(input int op, input logic sel);
        logic [9:0] f;
        int v, r, c;
        f = '0;
        f[9] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r = i / 2;
            c = i % 2;
            if (op == 1)
                v = sel ? mb[i] : ma[i];
            else if (op == 2)
                v = (ma[i] + mb[i]) % 4;
            else
                v = (ma[r*2] * mb[c] + ma[r*2+1] * mb[2+c]) % 4;
            f[8-2*i -: 2] = 2'(v);
        end
        return f;
    endfunction

    task automatic write_mat(input logic sel, input int ad[4], input int dt[4], input int maxgap);
        issue(0, sel);
        for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(0, maxgap)) idle_step();
            step(1'b1, 2'(ad[b]), 2'(dt[b]));
            if (sel) mb[ad[b]] = dt[b];
            else     ma[ad[b]] = dt[b];
        end
    endtask

    initial begin
        vec_t       vecs[5];
        logic [9:0] got;
        int         ad[4];
        int         dt[4];
        int         op;
        logic       sel;

        vecs[0] = '{"read_a", 1, 1'b0, 10'b1_01101100_0};
        vecs[1] = '{"read_b", 1, 1'b1, 10'b1_11110110_0};
        vecs[2] = '{"add",    2, 1'b0, 10'b1_00010010_0};
        vecs[3] = '{"mul",    3, 1'b0, 10'b1_01110101_0};
        vecs[4] = '{"add_sel1", 2, 1'b1, 10'b1_00010010_0};

        for (int i = 0; i < 4; i++) begin ma[i] = 0; mb[i] = 0; end

        rst = 1'b0; enter = 1'b0; X = '0; Y = '0;
        #3;
        check("reset_z", {9'b0, Z}, 10'b0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        repeat (3) idle_step();
        check("idle_z", {9'b0, Z}, 10'b0);

        issue(1, 1'b0);
        check("e0_z", {9'b0, Z}, 10'b0);
        collect(1'b0, 0, 1'b0, got);
        check("read_zero", got, 10'b1_00000000_0);

        // Load A, then B with gaps
        ad = '{0, 1, 2, 3};
        dt = '{1, 2, 3, 0};
        write_mat(1'b0, ad, dt, 0);
        issue(0, 1'b1);
        step(1'b1, 2'd0, 2'd3);
        idle_step();
        step(1'b1, 2'd1, 2'd3);
        idle_step();
        idle_step();
        step(1'b1, 2'd2, 2'd1);
        step(1'b1, 2'd3, 2'd2);
        mb = '{3, 3, 1, 2};

        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].op, vecs[i].sel);
            collect(1'b0, 0, 1'b0, got);
            check(vecs[i].name, got, vecs[i].exp);
        end

        // Back-to-back: MUL captured on the closing edge of a READ frame
        issue(1, 1'b0);
        collect(1'b1, 3, 1'b0, got);
        check("chain_first", got, 10'b1_01101100_0);
        collect(1'b0, 0, 1'b0, got);
        check("chain_second", got, 10'b1_01110101_0);

        // enter held with X=0 during a frame: frame intact, no WR entered
        issue(1, 1'b1);
        got = '0;
        for (int k = 0; k < 10; k++) begin
            if (k < 9) step(1'b1, 2'd0, 2'($urandom_range(0, 3)));
            else       idle_step();
            got = {got[8:0], Z};
        end
        check("hold_enter_frame", got, 10'b1_11110110_0);
        issue(1, 1'b0);
        collect(1'b0, 0, 1'b0, got);
        check("hold_enter_no_wr", got, 10'b1_01101100_0);

        // Fifth beat right after WR completes is a READ command
        write_mat(1'b0, ad, dt, 0);
        issue(1, 1'b0);
        collect(1'b0, 0, 1'b0, got);
        check("fifth_beat_cmd", got, 10'b1_01101100_0);

        // Randomised writes (duplicate addresses allowed) and commands
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                sel = 1'($urandom_range(0, 1));
                for (int b = 0; b < 4; b++) begin
                    ad[b] = $urandom_range(0, 3);
                    dt[b] = $urandom_range(0, 3);
                end
                write_mat(sel, ad, dt, 3);
            end else begin
                op  = $urandom_range(1, 3);
                sel = 1'($urandom_range(0, 1));
                issue(op, sel);
                collect(1'b0, 0, 1'b0, got);
                check($sformatf("rand_op%0d_sel%0d", op, sel), got, expected(op, sel));
            end
        end

        // Reset mid-frame: Z drops at once, matrices clear
        ad = '{0, 1, 2, 3};
        dt = '{1, 2, 3, 0};
        write_mat(1'b0, ad, dt, 0);
        issue(1, 1'b0);
        idle_step();
        check("pre_reset_start", {9'b0, Z}, 10'b1);
        #2 rst = 1'b0;
        #1;
        check("reset_midframe_z", {9'b0, Z}, 10'b0);
        #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin ma[i] = 0; mb[i] = 0; end
        @(posedge clk); #1;
        check("post_reset_idle", {9'b0, Z}, 10'b0);
        issue(1, 1'b0);
        collect(1'b0, 0, 1'b0, got);
        check("post_reset_read", got, expected(1, 1'b0));
        issue(3, 1'b0);
        collect(1'b0, 0, 1'b0, got);
        check("post_reset_mul", got, 10'b1_00000000_0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
